dump_seq: RTL



---
 rtl/dump_seq_pkg.sv | 7 +
 rtl/dump_seq_phase_timer.sv | 18 +
 rtl/dump_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/dump_seq_pkg.sv
// dump_seq_pkg: state encoding and default widths shared by the dump sequencer.
package dump_seq_pkg;
  localparam int TW_DEF = 12;
  localparam int NW_DEF = 16;
  localparam int INT_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, ON, DUMP, GAP, DONE} state_t;
endpackage

// File: rtl/dump_seq_phase_timer.sv
// phase_timer: down-counter reloaded on phase entry; a load of 0 behaves as 1.
module phase_timer #(
  parameter int W = 12
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_sys) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val == '0 ? W'(1) : load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign last = cnt == W'(1);
endmodule

// File: rtl/dump_seq.sv
// dump_seq: rt_sw / soft_dump period sequencer with done pulse.
// Define DUMP_SEQ_ABORT_EN to add the abort input.
module dump_seq
  import dump_seq_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int NW = NW_DEF,
  parameter int INT_W = INT_W_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          start,
`ifdef DUMP_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic [NW-1:0] n_per,
  input  logic [TW-1:0] t_on,
  input  logic [TW-1:0] t_dump,
  input  logic [TW-1:0] t_gap,
  output logic          rt_sw_o,
  output logic          s_dump_o,
  output logic          inter_n_o,
  output logic          busy
);
  localparam int IW = $clog2(INT_W + 1);
  localparam int CW = TW > IW ? TW : IW;
  state_t state, nxt;
  logic [NW-1:0] n_q, per_cnt, per_inc;
  logic [TW-1:0] on_q, dump_q, gap_q;
  logic ld, last;
  logic [CW-1:0] ld_val;
  assign per_inc = per_cnt + 1'b1;
  always_comb begin
    nxt = state;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: if (start) begin
        nxt = n_per == '0 ? DONE : ON;
        ld = 1'b1;
        ld_val = n_per == '0 ? CW'(INT_W) : CW'(t_on);
      end
      ON: if (last) begin
        nxt = DUMP;
        ld = 1'b1;
        ld_val = CW'(dump_q);
      end
      DUMP: if (last) begin
        nxt = GAP;
        ld = 1'b1;
        ld_val = CW'(gap_q);
      end
      GAP: if (last) begin
        nxt = per_inc < n_q ? ON : DONE;
        ld = 1'b1;
        ld_val = per_inc < n_q ? CW'(on_q) : CW'(INT_W);
      end
      DONE: if (last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef DUMP_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      nxt = IDLE;
      ld = 1'b0;
    end
`endif
  end
  phase_timer #(.W(CW)) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .load    (ld),
    .load_val(ld_val),
    .last    (last)
  );
  // outputs are decoded from the next state so they line up with the registered state
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
      rt_sw_o <= 1'b0;
      s_dump_o <= 1'b0;
      inter_n_o <= 1'b1;
      busy <= 1'b0;
      per_cnt <= '0;
      n_q <= '0;
      on_q <= '0;
      dump_q <= '0;
      gap_q <= '0;
    end else begin
      state <= nxt;
      rt_sw_o <= nxt == ON;
      s_dump_o <= nxt == DUMP;
      inter_n_o <= nxt != DONE;
      busy <= nxt != IDLE;
      if (state == IDLE && start) begin
        n_q <= n_per;
        on_q <= t_on;
        dump_q <= t_dump;
        gap_q <= t_gap;
        per_cnt <= '0;
      end else if (state == GAP && last) per_cnt <= per_inc;
    end
  end
endmodule
